// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, ALUOp codes, FSM states,
// datapath mux encodings and the control vector. MC_JAL_EN adds the JAL instruction.
package mips_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  // Consumed by the ALU control decoder as well.
  localparam logic [2:0] AluOpIdle  = 3'b000;
  localparam logic [2:0] AluOpSub   = 3'b001;
  localparam logic [2:0] AluOpAdd   = 3'b100;
  localparam logic [2:0] AluOpOr    = 3'b101;
  localparam logic [2:0] AluOpRtype = 3'b111;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAddr  = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StRExec    = 4'd7,
    StRWb      = 4'd8,
    StIExec    = 4'd9,
    StIWb      = 4'd10,
    StBranch   = 4'd11,
    StJump     = 4'd12,
    StJal      = 4'd13
  } state_e;

  localparam logic [1:0] RegDstRt = 2'b00;
  localparam logic [1:0] RegDstRd = 2'b01;
  localparam logic [1:0] RegDstRa = 2'b10;

  localparam logic [1:0] MemToRegAlu = 2'b00;
  localparam logic [1:0] MemToRegMdr = 2'b01;
  localparam logic [1:0] MemToRegPc  = 2'b10;

  localparam logic [1:0] AluSrcBReg   = 2'b00;
  localparam logic [1:0] AluSrcBFour  = 2'b01;
  localparam logic [1:0] AluSrcBImm   = 2'b10;
  localparam logic [1:0] AluSrcBImmSh = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_ncond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outputs.sv
// Combinational decode of FSM state and latched opcode into the datapath control vector.
module mc_ctrl_outputs
  import mips_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] op_q,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      StIdle: ;
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = AluSrcBFour;
        ctrl.alu_op    = AluOpAdd;
        // IR and PC only commit once the fetch actually completes.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      StDecode: begin
        ctrl.alu_src_b = AluSrcBImmSh;
        ctrl.alu_op    = AluOpAdd;
      end
      StMemAddr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = AluSrcBImm;
        ctrl.alu_op    = AluOpAdd;
      end
      StMemRead: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_dst    = RegDstRt;
        ctrl.mem_to_reg = MemToRegMdr;
        ctrl.reg_write  = 1'b1;
      end
      StMemWrite: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      StRExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = AluSrcBReg;
        ctrl.alu_op    = AluOpRtype;
      end
      StRWb: begin
        ctrl.reg_dst    = RegDstRd;
        ctrl.mem_to_reg = MemToRegAlu;
        ctrl.reg_write  = 1'b1;
      end
      StIExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = AluSrcBImm;
        if (op_q == OpOri) begin
          ctrl.alu_op   = AluOpOr;
          ctrl.zero_ext = 1'b1;
        end else begin
          ctrl.alu_op   = AluOpAdd;
        end
      end
      StIWb: begin
        ctrl.reg_dst    = RegDstRt;
        ctrl.mem_to_reg = MemToRegAlu;
        ctrl.reg_write  = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a      = 1'b1;
        ctrl.alu_src_b      = AluSrcBReg;
        ctrl.alu_op         = AluOpSub;
        ctrl.pc_source      = PcSrcAluOut;
        ctrl.pc_write_cond  = (op_q == OpBeq);
        ctrl.pc_write_ncond = (op_q == OpBne);
      end
      StJump: begin
        ctrl.pc_source = PcSrcJump;
        ctrl.pc_write  = 1'b1;
      end
      StJal: begin
        ctrl.pc_source  = PcSrcJump;
        ctrl.pc_write   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RegDstRa;
        ctrl.mem_to_reg = MemToRegPc;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: state register, latched opcode and
// next-state logic. Defining MC_JAL_EN adds the JAL instruction.
module multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_write_ncond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       zero_ext,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  ctrl_t      ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    illegal_op = 1'b0;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (mem_ready) state_d = StDecode;
      StDecode: begin
        // Decode uses the live opcode; later states use op_q.
        op_d = opcode;
        case (opcode)
          OpRtype:      state_d = StRExec;
          OpLw, OpSw:   state_d = StMemAddr;
          OpAddi, OpOri: state_d = StIExec;
          OpBeq, OpBne: state_d = StBranch;
          OpJ:          state_d = StJump;
`ifdef MC_JAL_EN
          OpJal:        state_d = StJal;
`endif
          default: begin
            state_d    = StFetch;
            illegal_op = 1'b1;
          end
        endcase
      end
      StMemAddr:  state_d = (op_q == OpSw) ? StMemWrite : StMemRead;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StRExec:    state_d = StRWb;
      StRWb:      state_d = StFetch;
      StIExec:    state_d = StIWb;
      StIWb:      state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJump:     state_d = StFetch;
      StJal:      state_d = StFetch;
      default:    state_d = StIdle;
    endcase
  end

  mc_ctrl_outputs u_outputs (
    .state     (state_q),
    .op_q      (op_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write       = ctrl.pc_write;
  assign pc_write_cond  = ctrl.pc_write_cond;
  assign pc_write_ncond = ctrl.pc_write_ncond;
  assign i_or_d         = ctrl.i_or_d;
  assign mem_read       = ctrl.mem_read;
  assign mem_write      = ctrl.mem_write;
  assign ir_write       = ctrl.ir_write;
  assign reg_write      = ctrl.reg_write;
  assign reg_dst        = ctrl.reg_dst;
  assign mem_to_reg     = ctrl.mem_to_reg;
  assign alu_src_a      = ctrl.alu_src_a;
  assign alu_src_b      = ctrl.alu_src_b;
  assign zero_ext       = ctrl.zero_ext;
  assign pc_source      = ctrl.pc_source;
  assign alu_op         = ctrl.alu_op;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against an instruction-level step model.
// Honours MC_JAL_EN the same way as the design.
module tb_multicycle_control;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, pc_write_ncond, i_or_d;
  logic       mem_read, mem_write, ir_write, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic       alu_src_a, zero_ext, illegal_op;
  logic [2:0] alu_op;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk            (clk),
    .reset          (reset),
    .opcode         (opcode),
    .mem_ready      (mem_ready),
    .pc_write       (pc_write),
    .pc_write_cond  (pc_write_cond),
    .pc_write_ncond (pc_write_ncond),
    .i_or_d         (i_or_d),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .ir_write       (ir_write),
    .reg_write      (reg_write),
    .reg_dst        (reg_dst),
    .mem_to_reg     (mem_to_reg),
    .alu_src_a      (alu_src_a),
    .alu_src_b      (alu_src_b),
    .zero_ext       (zero_ext),
    .pc_source      (pc_source),
    .alu_op         (alu_op),
    .illegal_op     (illegal_op),
    .state_dbg      (state_dbg)
  );

  typedef enum int {
    KIdle, KFetch, KDecode, KMemAddr, KMemRead, KMemWb, KMemWrite,
    KRExec, KRWb, KIExec, KIWb, KBranch, KJump, KJal
  } step_t;

  typedef struct packed {
    logic       pc_write, pc_write_cond, pc_write_ncond, i_or_d;
    logic       mem_read, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;
  } obs_t;

  step_t      step_q[$];
  logic [5:0] dir_ops[$];
  logic [5:0] cur_op;
  int         cycles, waits;
  int         errors = 0;
  int         checks = 0;
  logic [5:0] op_pool [10] = '{6'h00, 6'h23, 6'h2b, 6'h08, 6'h0d,
                               6'h04, 6'h05, 6'h02, 6'h03, 6'h3f};

  function automatic bit jal_on();
`ifdef MC_JAL_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return (op inside {6'h00, 6'h23, 6'h2b, 6'h08, 6'h0d, 6'h04, 6'h05, 6'h02})
           || (op == 6'h03 && jal_on());
  endfunction

  // FETCH-to-FETCH cycle counts with zero wait states.
  function automatic int base_len(input logic [5:0] op);
    if (!legal(op)) return 2;
    case (op)
      6'h23:                      return 5;
      6'h00, 6'h08, 6'h0d, 6'h2b: return 4;
      default:                    return 3;
    endcase
  endfunction

  function automatic obs_t expect_obs(input step_t s, input logic [5:0] op, input logic mr);
    obs_t e;
    e = '0;
    case (s)
      KFetch: begin
        e.mem_read = 1; e.alu_src_b = 2'b01; e.alu_op = 3'b100;
        e.ir_write = mr; e.pc_write = mr; e.state = StFetch;
      end
      KDecode: begin
        e.alu_src_b = 2'b11; e.alu_op = 3'b100; e.illegal_op = !legal(op); e.state = StDecode;
      end
      KMemAddr: begin
        e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 3'b100; e.state = StMemAddr;
      end
      KMemRead:  begin e.mem_read = 1; e.i_or_d = 1; e.state = StMemRead; end
      KMemWb:    begin e.mem_to_reg = 2'b01; e.reg_write = 1; e.state = StMemWb; end
      KMemWrite: begin e.mem_write = 1; e.i_or_d = 1; e.state = StMemWrite; end
      KRExec:    begin e.alu_src_a = 1; e.alu_op = 3'b111; e.state = StRExec; end
      KRWb:      begin e.reg_dst = 2'b01; e.reg_write = 1; e.state = StRWb; end
      KIExec: begin
        e.alu_src_a = 1; e.alu_src_b = 2'b10; e.state = StIExec;
        e.alu_op = (op == 6'h0d) ? 3'b101 : 3'b100;
        e.zero_ext = (op == 6'h0d);
      end
      KIWb: begin e.reg_write = 1; e.state = StIWb; end
      KBranch: begin
        e.alu_src_a = 1; e.alu_op = 3'b001; e.pc_source = 2'b01; e.state = StBranch;
        e.pc_write_cond = (op == 6'h04); e.pc_write_ncond = (op == 6'h05);
      end
      KJump: begin e.pc_source = 2'b10; e.pc_write = 1; e.state = StJump; end
      KJal: begin
        e.pc_source = 2'b10; e.pc_write = 1; e.reg_write = 1;
        e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; e.state = StJal;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic obs_t actual();
    obs_t a;
    a = '{pc_write, pc_write_cond, pc_write_ncond, i_or_d, mem_read, mem_write, ir_write,
          reg_write, illegal_op, reg_dst, mem_to_reg, alu_src_a, alu_src_b, zero_ext,
          pc_source, alu_op, state_dbg};
    return a;
  endfunction

  task automatic start_inst();
    if (dir_ops.size() > 0) cur_op = dir_ops.pop_front();
    else if ($urandom_range(0, 7) == 0) cur_op = 6'($urandom);
    else cur_op = op_pool[$urandom_range(0, 9)];
    step_q = '{KFetch, KDecode};
    if (legal(cur_op)) begin
      case (cur_op)
        6'h00:        begin step_q.push_back(KRExec); step_q.push_back(KRWb); end
        6'h23: begin
          step_q.push_back(KMemAddr); step_q.push_back(KMemRead); step_q.push_back(KMemWb);
        end
        6'h2b:        begin step_q.push_back(KMemAddr); step_q.push_back(KMemWrite); end
        6'h08, 6'h0d: begin step_q.push_back(KIExec); step_q.push_back(KIWb); end
        6'h04, 6'h05: step_q.push_back(KBranch);
        6'h02:        step_q.push_back(KJump);
        6'h03:        step_q.push_back(KJal);
        default: ;
      endcase
    end
    cycles = 0;
    waits  = 0;
  endtask

  task automatic model_reset();
    step_q = '{KIdle};
    cycles = 0;
    waits  = 0;
  endtask

  task automatic compare(input logic mr);
    obs_t e, a;
    e = expect_obs(step_q[0], cur_op, mr);
    a = actual();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL outputs step=%0d op=%b: got %h want %h", step_q[0], cur_op, a, e);
    end
    checks++;
    if (mem_write && reg_write) begin
      errors++;
      $display("FAIL wr_exclusive: mem_write=%b reg_write=%b want not both", mem_write, reg_write);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic sample(input logic mr);
    @(negedge clk);
    if (step_q.size() == 0) start_inst();
    mem_ready = mr;
    // Opcode is only guaranteed during DECODE; scramble it elsewhere.
    opcode = (step_q[0] == KDecode) ? cur_op : 6'($urandom);
    #1;
    compare(mr);
  endtask

  task automatic advance();
    step_t s;
    @(posedge clk);
    if (!reset) return;
    s = step_q[0];
    cycles++;
    if ((s inside {KFetch, KMemRead, KMemWrite}) && !mem_ready) begin
      waits++;
    end else begin
      void'(step_q.pop_front());
      if (step_q.size() == 0 && s != KIdle) begin
        checks++;
        if (cycles != base_len(cur_op) + waits) begin
          errors++;
          $display("FAIL inst_len op=%b: got %0d want %0d", cur_op, cycles,
                   base_len(cur_op) + waits);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    opcode = '0;
    model_reset();
    dir_ops = '{6'h00, 6'h23, 6'h0d, 6'h08, 6'h04, 6'h05, 6'h03, 6'h2b};
    #2 reset = 1'b0;

    sample(1); chk("reset_state", state_dbg, 0); chk("reset_mem_read", mem_read, 0);
    reset = 1'b1;
    advance();

    // R-type, zero wait states
    sample(1); chk("fetch_state", state_dbg, 1); chk("fetch_mem_read", mem_read, 1);
    chk("fetch_alu_op", alu_op, 3'b100); chk("fetch_ir_write", ir_write, 1); advance();
    sample(1); advance();
    sample(1); chk("rexec_alu_op", alu_op, 3'b111); advance();
    sample(1); chk("rwb_reg_write", reg_write, 1); chk("rwb_reg_dst", reg_dst, 1); advance();

    // LW with two wait cycles in MEM_READ
    sample(1); chk("r_back_to_fetch", state_dbg, 1); advance();
    sample(1); advance();
    sample(1); advance();
    sample(0); chk("lw_read_1", mem_read, 1); advance();
    sample(0); chk("lw_read_2", mem_read, 1); advance();
    sample(1); chk("lw_read_3", mem_read, 1); chk("lw_i_or_d", i_or_d, 1); advance();
    sample(1); chk("lw_wb_m2r", mem_to_reg, 1); advance();

    // ORI then ADDI
    sample(1); advance(); sample(1); advance();
    sample(1); chk("ori_alu_op", alu_op, 3'b101); chk("ori_zext", zero_ext, 1); advance();
    sample(1); advance();
    sample(1); advance(); sample(1); advance();
    sample(1); chk("addi_alu_op", alu_op, 3'b100); chk("addi_zext", zero_ext, 0); advance();
    sample(1); advance();

    // BEQ then BNE
    sample(1); advance(); sample(1); advance();
    sample(1); chk("beq_cond", {pc_write_cond, pc_write_ncond}, 2'b10);
    chk("beq_alu_op", alu_op, 3'b001); chk("beq_pc_src", pc_source, 1); advance();
    sample(1); advance(); sample(1); advance();
    sample(1); chk("bne_cond", {pc_write_cond, pc_write_ncond}, 2'b01); advance();

    // Opcode 000011
    sample(1); advance();
    sample(1); chk("op3_illegal", illegal_op, jal_on() ? 0 : 1); advance();
`ifdef MC_JAL_EN
    sample(1); chk("jal_reg_write", reg_write, 1); chk("jal_reg_dst", reg_dst, 2);
    chk("jal_m2r", mem_to_reg, 2); chk("jal_pc_write", pc_write, 1); advance();
`endif

    // SW, reset while waiting in MEM_WRITE
    sample(1); chk("op3_then_fetch", state_dbg, 1); advance();
    sample(1); advance();
    sample(1); advance();
    sample(0); chk("sw_mem_write", mem_write, 1);
    reset = 1'b0;
    #1;
    chk("rst_drop_mem_write", mem_write, 0); chk("rst_idle", state_dbg, 0);
    model_reset();
    advance();
    sample(1); chk("rst_hold_idle", state_dbg, 0);
    reset = 1'b1;
    advance();
    sample(1); chk("rel_fetch_read", mem_read, 1); chk("rel_fetch_alu", alu_op, 3'b100);
    advance();

    for (int i = 0; i < 4000; i++) begin
      sample($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 249) == 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        compare(1'b0);
        advance();
        sample(1'b1);
        reset = 1'b1;
      end
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives all datapath enables and muxes, and produces the 3-bit ALUOp code that the ALU control decoder consumes. Memory accesses wait on a ready handshake.

## Interface
- No parameters; opcode/ALUOp codes come from the shared package.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes access this cycle
- pc_write, pc_write_cond, pc_write_ncond  out  1 each  PC enable; conditional on ALU zero / not-zero
- i_or_d  out  1  0 = PC address, 1 = ALUOut address
- mem_read, mem_write, ir_write, reg_write  out  1 each
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- alu_src_a  out  1  0 PC, 1 A
- alu_src_b  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- zero_ext  out  1  immediate zero-extended (ORI)
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alu_op  out  3  111 R-type, 100 add, 101 or, 001 subtract/compare, 000 idle
- illegal_op  out  1  unsupported opcode seen in DECODE
- state_dbg  out  4  current state encoding

## Operation
- Moore FSM. All outputs decode combinationally from the state register and latched opcode op_q. The only exception is FETCH, where ir_write and pc_write also require mem_ready (Mealy).
- op_q latches opcode on the DECODE cycle.
- IDLE: all outputs 0. Next state is always FETCH.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=100, pc_source=00. ir_write=pc_write=mem_ready. The FSM stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=100 (branch target into ALUOut). Next state by opcode:
  - 000000 → R_EXEC
  - 100011 or 101011 → MEM_ADDR
  - 001000 or 001101 → I_EXEC
  - 000100 or 000101 → BRANCH
  - 000010 → JUMP
  - any other opcode → FETCH, with illegal_op=1 for this cycle
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=100. Next: MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: mem_read=1, i_or_d=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: reg_dst=00, mem_to_reg=01, reg_write=1. Next: FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Waits for mem_ready, then goes to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=111. Next: R_WB.
- R_WB: reg_dst=01, mem_to_reg=00, reg_write=1. Next: FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10. ADDI uses alu_op=100; ORI uses alu_op=101 with zero_ext=1. Next: I_WB.
- I_WB: reg_dst=00, mem_to_reg=00, reg_write=1. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=01. BEQ asserts pc_write_cond; BNE asserts pc_write_ncond. Next: FETCH.
- JUMP: pc_source=10, pc_write=1. Next: FETCH.
- mem_write and reg_write are never asserted in the same cycle.

## Timing
- Zero-wait-state cycle counts (FETCH to next FETCH): BEQ/BNE/J 3; R-type, ADDI, ORI, SW 4; LW 5.
- Each cycle that mem_ready is low in FETCH, MEM_READ or MEM_WRITE adds one cycle. Request outputs are held stable for the whole wait.
- Reset assertion at any time:
  - state goes to IDLE and op_q to 0 immediately (asynchronous); all outputs go to 0 in the same cycle.
  - An in-flight mem_write or reg_write is dropped.
- After reset deasserts, the first rising edge moves IDLE→FETCH.

## Configuration
- MC_JAL_EN defined:
  - Opcode 000011 in DECODE → JAL state.
  - JAL state: pc_source=10, pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10 (writes PC+4 into $31). Next: FETCH. 3 cycles total.
- MC_JAL_EN undefined: opcode 000011 is illegal (illegal_op pulse, return to FETCH).

## Structure
- Shared package mips_pkg holds:
  - opcode localparams
  - ALUOp codes (111/100/101/001), shared with the ALU control decoder
  - state enum (4-bit)
  - mux-select encodings for reg_dst, mem_to_reg, alu_src_b and pc_source
- One sub-module, mc_ctrl_outputs: purely combinational state/op_q/mem_ready → control-vector decode. Top level holds the state register, op_q and next-state logic.

## Test plan
- Reset low mid-MEM_WRITE → mem_write drops to 0 and state_dbg=IDLE the same cycle. After release: IDLE, then FETCH with mem_read=1, alu_op=100.
- R-type (opcode 000000), mem_ready tied 1 → FETCH/DECODE/R_EXEC(alu_op=111)/R_WB(reg_write=1, reg_dst=01); back to FETCH in cycle 5.
- LW with mem_ready low for 2 cycles in MEM_READ → mem_read held 3 cycles; MEM_WB has mem_to_reg=01; total 7 cycles.
- ORI (001101) → I_EXEC shows alu_op=101, zero_ext=1; ADDI (001000) shows alu_op=100, zero_ext=0.
- BEQ then BNE → BRANCH asserts pc_write_cond only, then pc_write_ncond only; alu_op=001, pc_source=01; 3 cycles each.
- Opcode 000011 → with MC_JAL_EN: reg_write=1, reg_dst=10, mem_to_reg=10, pc_write=1. Without MC_JAL_EN: illegal_op=1 for one cycle, then FETCH.
